// File: rtl/pc_fetch_unit.sv
// IF-stage program counter and fetch sequencer: redirect, memory handshake, stall skid, IF/ID register.
// Optional accepted-fetch counter enabled by defining PC_FETCH_COUNT_EN; otherwise FetchCount is 0.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Stall,
    input  logic        IMemReady,
    input  logic [31:0] IMemInstr,
    output logic [31:0] PCResult,
    output logic        IMemReq,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_Instr,
    output logic        IFID_Valid,
    output logic        MisalignErr,
    output logic        TimeoutErr,
    output logic [31:0] FetchCount
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [3:0]  wait_q, wait_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;
    logic        accept;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;
        wait_d       = wait_q;
        misalign_d   = misalign_q;
        timeout_d    = timeout_q;
        accept       = 1'b0;

        if (state_q == ST_BOOT) begin
            state_d = ST_FETCH;
        end else if (BranchTaken) begin
            // Redirect wins over stall and drops any response arriving this cycle.
            pc_d         = {BranchTarget[31:2], 2'b00};
            ifid_valid_d = 1'b0;
            wait_d       = 4'd0;
            state_d      = ST_FETCH;
            if (BranchTarget[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (state_q == ST_FETCH) begin
            if (IMemReady && !Stall) begin
                ifid_pc4_d   = PCAddResult;
                ifid_instr_d = IMemInstr;
                ifid_valid_d = 1'b1;
                pc_d         = PCAddResult;
                wait_d       = 4'd0;
                accept       = 1'b1;
            end else if (IMemReady) begin
                skid_pc4_d   = PCAddResult;
                skid_instr_d = IMemInstr;
                state_d      = ST_HOLD;
            end else begin
                if (!Stall) begin
                    ifid_valid_d = 1'b0;
                end
                if (wait_q != WAIT_LIMIT) begin
                    wait_d = wait_q + 4'd1;
                end
                if (wait_d == WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                end
            end
        end else if (state_q == ST_HOLD) begin
            if (!Stall) begin
                ifid_pc4_d   = skid_pc4_q;
                ifid_instr_d = skid_instr_q;
                ifid_valid_d = 1'b1;
                pc_d         = PCAddResult;
                wait_d       = 4'd0;
                accept       = 1'b1;
                state_d      = ST_FETCH;
            end
        end else begin
            state_d = ST_BOOT;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= 32'd0;
            ifid_valid_q <= 1'b0;
            skid_pc4_q   <= 32'd0;
            skid_instr_q <= 32'd0;
            wait_q       <= 4'd0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
            wait_q       <= wait_d;
            misalign_q   <= misalign_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef PC_FETCH_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= 32'd0;
        end else if (accept) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign FetchCount = count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign FetchCount    = 32'd0;
`endif

    assign PCResult    = pc_q;
    assign IMemReq     = (state_q == ST_FETCH);
    assign IFID_PC4    = ifid_pc4_q;
    assign IFID_Instr  = ifid_instr_q;
    assign IFID_Valid  = ifid_valid_q;
    assign MisalignErr = misalign_q;
    assign TimeoutErr  = timeout_q;

endmodule
